// File: rtl/sram_arb_pkg.sv
// Purpose: shared types and constants for the eLC-3 SRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int DEF_RD_WAIT = 2;
  localparam int DEF_WR_WAIT = 2;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_CPU = 0;
  localparam int GNT_LD  = 1;

  // Wait-counter load value for the ACCESS phase of a given direction.
  function automatic logic [3:0] wait_load(input logic rw, input int rd_w, input int wr_w);
    return (rw == RW_WRITE) ? 4'(wr_w) : 4'(rd_w);
  endfunction

endpackage

// File: rtl/sram_arbiter_rr2.sv
// Purpose: 2-way alternating-priority grant; on contention the side not granted last wins.
// Latency: combinational, zero cycles.
// Backpressure: grants nothing while en is low; requests are simply re-evaluated later.
module arb_rr2
  import sram_arb_pkg::*;
(
  input  logic       req_cpu,
  input  logic       req_ld,
  input  req_id_t    last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  // One-hot grant: single requester wins outright, contention alternates.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req_cpu && req_ld) begin
        if (last_grant == REQ_LD) gnt[GNT_CPU] = 1'b1;
        else                      gnt[GNT_LD]  = 1'b1;
      end else if (req_cpu) begin
        gnt[GNT_CPU] = 1'b1;
      end else if (req_ld) begin
        gnt[GNT_LD] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Purpose: shares one 16-bit async SRAM between the CPU port and the program loader, generating CE/OE/WE sequences.
// Latency: ack in cycle 2+WAIT after the request is sampled in IDLE; back-to-back period 3+WAIT.
// Backpressure: requests are held level until ack; a losing requester waits in IDLE. Optional macro SRAM_ARB_BYTE_LANE_EN adds CPU_ByteSel.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int         RD_WAIT = DEF_RD_WAIT,
  parameter int         WR_WAIT = DEF_WR_WAIT,
  parameter logic [3:0] ADDR_HI = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CPU_Req,
  input  logic        CPU_RW,
  input  logic [15:0] CPU_Addr,
  input  logic [15:0] CPU_WData,
`ifdef SRAM_ARB_BYTE_LANE_EN
  input  logic [1:0]  CPU_ByteSel,
`endif
  output logic [15:0] CPU_RData,
  output logic        CPU_Ack,
  input  logic        LD_Req,
  input  logic [15:0] LD_Addr,
  input  logic [15:0] LD_WData,
  output logic        LD_Ack,
  output logic        Busy,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_Out,
  output logic        SRAM_DQ_OE,
  input  logic [15:0] SRAM_DQ_In
);

  arb_state_t  state, state_nxt;
  logic [3:0]  cnt;
  logic        rw_q;
  req_id_t     id_q;
  req_id_t     last_grant;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic [1:0]  lanes_q;   // bit0 = low byte enabled, bit1 = high byte enabled
  logic [1:0]  gnt;
  logic [1:0]  cpu_lanes;
  logic        is_wr;
  logic        last_access;

`ifdef SRAM_ARB_BYTE_LANE_EN
  assign cpu_lanes = CPU_ByteSel;
`else
  assign cpu_lanes = 2'b11;
`endif

  assign is_wr       = (rw_q == RW_WRITE);
  assign last_access = (state == ACCESS) && (cnt == 4'd1);

  arb_rr2 u_rr2 (
    .req_cpu    (CPU_Req),
    .req_ld     (LD_Req),
    .last_grant (last_grant),
    .en         (state == IDLE),
    .gnt        (gnt)
  );

  // State register; reset drops any access in flight, truncating a write pulse.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and SRAM strobes, all decoded from registered state.
  always_comb begin
    state_nxt  = state;
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    SRAM_LB_N  = 1'b1;
    SRAM_UB_N  = 1'b1;
    SRAM_DQ_OE = 1'b0;
    CPU_Ack    = 1'b0;
    LD_Ack     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|gnt) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt  = ACCESS;
        SRAM_CE_N  = 1'b0;
        SRAM_LB_N  = ~lanes_q[0];
        SRAM_UB_N  = ~lanes_q[1];
        SRAM_DQ_OE = is_wr;
      end
      ACCESS: begin
        if (cnt == 4'd1) state_nxt = DONE;
        SRAM_CE_N  = 1'b0;
        SRAM_LB_N  = ~lanes_q[0];
        SRAM_UB_N  = ~lanes_q[1];
        SRAM_DQ_OE = is_wr;
        SRAM_WE_N  = ~is_wr;
        SRAM_OE_N  = is_wr;
      end
      DONE: begin
        state_nxt  = IDLE;
        SRAM_CE_N  = 1'b0;
        SRAM_LB_N  = ~lanes_q[0];
        SRAM_UB_N  = ~lanes_q[1];
        // Keep driving write data one more cycle for hold time after WE_N rises.
        SRAM_DQ_OE = is_wr;
        CPU_Ack    = (id_q == REQ_CPU);
        LD_Ack     = (id_q == REQ_LD);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, wait counter and read-data capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt        <= 4'd0;
      rw_q       <= RW_READ;
      id_q       <= REQ_LD;
      last_grant <= REQ_LD;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      rdata_q    <= 16'h0000;
      lanes_q    <= 2'b11;
    end else begin
      if (state == IDLE && gnt[GNT_LD]) begin
        rw_q       <= RW_WRITE;
        id_q       <= REQ_LD;
        last_grant <= REQ_LD;
        addr_q     <= LD_Addr;
        wdata_q    <= LD_WData;
        lanes_q    <= 2'b11;
      end else if (state == IDLE && gnt[GNT_CPU]) begin
        rw_q       <= CPU_RW;
        id_q       <= REQ_CPU;
        last_grant <= REQ_CPU;
        addr_q     <= CPU_Addr;
        wdata_q    <= CPU_WData;
        lanes_q    <= cpu_lanes;
      end
      if (state == SETUP)  cnt <= wait_load(rw_q, RD_WAIT, WR_WAIT);
      if (state == ACCESS) cnt <= cnt - 4'd1;
      // CPU_RData only changes on a CPU read, so it survives loader traffic.
      if (last_access && !is_wr && id_q == REQ_CPU) rdata_q <= SRAM_DQ_In;
    end
  end

  assign Busy        = (state != IDLE);
  assign CPU_RData   = rdata_q;
  assign SRAM_ADDR   = {ADDR_HI, addr_q};
  assign SRAM_DQ_Out = wdata_q;

endmodule
